// File: rtl/mtime_counter_if.sv
// rtl/mtime_counter_if.sv - register slave bus between the memory interface and mtime_counter
interface mtime_counter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  we;
  logic                  re;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack;

  modport master (
    output addr, wdata, we, re,
    input  rdata, ack
  );

  modport slave (
    input  addr, wdata, we, re,
    output rdata, ack
  );
endinterface

// File: rtl/mtime_counter.sv
// rtl/mtime_counter.sv - 64-bit RISC-V mtime with programmable prescaler and coherent register access
module mtime_counter #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 32,
  parameter logic [31:0] DIV_DEFAULT = 32'd50
) (
  input  logic          clk,
  input  logic          rst,
  mtime_counter_if.slave bus,
  output logic [63:0]   time_value,
  output logic          tick
);

  localparam logic [1:0] REG_LO   = 2'd0;
  localparam logic [1:0] REG_HI   = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_DIV  = 2'd3;

  logic [DATA_WIDTH-1:0] div;
  logic [DATA_WIDTH-1:0] pre_cnt;
  logic [DATA_WIDTH-1:0] lo_stage;
  logic [DATA_WIDTH-1:0] hi_shadow;
  logic                  enable;
  logic                  ack_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [1:0]            sel;
  logic                  wr_en;
  logic                  rd_en;
  logic                  lo_wr;
  logic                  hi_commit;
  logic                  ctrl_wr;
  logic                  div_wr;
  logic                  lo_rd;
  logic [DATA_WIDTH-1:0] last_cnt;
  logic                  terminal;
  logic [DATA_WIDTH-1:0] rd_value;
  logic                  unused_addr;

  assign unused_addr = ^{bus.addr[ADDR_WIDTH-1:4], bus.addr[1:0]};

  // A write wins over a simultaneous read; the read is simply not performed.
  always_comb begin
    sel       = bus.addr[3:2];
    wr_en     = bus.we;
    rd_en     = bus.re & ~bus.we;
    lo_wr     = wr_en && (sel == REG_LO);
    hi_commit = wr_en && (sel == REG_HI);
    ctrl_wr   = wr_en && (sel == REG_CTRL);
    div_wr    = wr_en && (sel == REG_DIV);
    lo_rd     = rd_en && (sel == REG_LO);
  end

  // A divisor of zero behaves as one, so the terminal count is then zero.
  always_comb begin
    last_cnt = (div == '0) ? '0 : div - 1'b1;
    terminal = enable && (pre_cnt >= last_cnt);
  end

  always_comb begin
    rd_value = '0;
    if (rd_en) begin
      case (sel)
        REG_LO:   rd_value = time_value[31:0];
        REG_HI:   rd_value = hi_shadow;
        REG_CTRL: rd_value = {{(DATA_WIDTH-1){1'b0}}, enable};
        REG_DIV:  rd_value = div;
        default:  rd_value = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_value <= '0;
      tick       <= 1'b0;
      pre_cnt    <= '0;
      div        <= DIV_DEFAULT;
      enable     <= 1'b1;
      lo_stage   <= '0;
      hi_shadow  <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ack_q   <= bus.we | bus.re;
      rdata_q <= rd_value;

      // A HI commit overrides a coincident increment, which is then lost.
      if (hi_commit) begin
        time_value <= {bus.wdata, lo_stage};
      end else if (terminal) begin
        time_value <= time_value + 64'd1;
      end
      tick <= terminal & ~hi_commit;

      if (div_wr || terminal) begin
        pre_cnt <= '0;
      end else if (enable) begin
        pre_cnt <= pre_cnt + 1'b1;
      end

      // Shadow captures the pre-increment upper half alongside the LO read.
      if (lo_rd) begin
        hi_shadow <= time_value[63:32];
      end
      if (lo_wr) begin
        lo_stage <= bus.wdata;
      end
      if (ctrl_wr) begin
        enable <= bus.wdata[0];
      end
      if (div_wr) begin
        div <= bus.wdata;
      end
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mtime_counter.sv
// tb/tb_mtime_counter.sv - scoreboard bench for mtime_counter against a countdown reference model
module tb_mtime_counter;

  logic        clk;
  logic        rst;
  logic [63:0] time_value;
  logic        tick;

  mtime_counter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_if ();

  mtime_counter #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DIV_DEFAULT(32'd50)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .time_value(time_value),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  // Reference model: counts down the clocks left until the next increment.
  logic [63:0]  m_time;
  logic [31:0]  m_div, m_lo, m_shadow;
  logic         m_en, m_ack, m_tick;
  int unsigned  m_left;
  logic [31:0]  exp_q[$];

  function automatic int unsigned eff_div(input logic [31:0] d);
    return (d == 32'd0) ? 1 : int'(d);
  endfunction

  task automatic model_reset();
    m_time = 64'd0; m_div = 32'd50; m_lo = 32'd0; m_shadow = 32'd0;
    m_en = 1'b1; m_ack = 1'b0; m_tick = 1'b0; m_left = 50;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic        w, r, inc, commit;
    logic [1:0]  a;
    logic [31:0] d, rd;
    w = bus_if.we; r = bus_if.re; a = bus_if.addr[3:2]; d = bus_if.wdata;
    inc = 1'b0;
    if (m_en) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        inc = 1'b1;
        m_left = eff_div(m_div);
      end
    end
    commit = w && (a == 2'd1);
    rd = 32'd0;
    if (r && !w) begin
      case (a)
        2'd0: begin rd = m_time[31:0]; m_shadow = m_time[63:32]; end
        2'd1: rd = m_shadow;
        2'd2: rd = {31'd0, m_en};
        default: rd = m_div;
      endcase
    end
    if (commit) m_time = {d, m_lo};
    else if (inc) m_time = m_time + 64'd1;
    m_tick = inc && !commit;
    if (w) begin
      case (a)
        2'd0: m_lo = d;
        2'd2: m_en = d[0];
        2'd3: begin m_div = d; m_left = eff_div(d); end
        default: ;
      endcase
    end
    m_ack = w || r;
    if (m_ack) exp_q.push_back(rd);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Monitor: compares every cycle; pops an expected read word on each ack.
  initial begin
    forever begin
      @(negedge clk);
      if (tick === 1'b1) tick_cnt++;
      chk("ack", bus_if.ack, m_ack);
      chk("tick", tick, m_tick);
      chk("time_value", time_value, m_time);
      if (bus_if.ack === 1'b1) begin
        if (exp_q.size() > 0) chk("rdata", bus_if.rdata, exp_q.pop_front());
        else chk("ack_without_request", bus_if.ack, 0);
      end else begin
        chk("rdata_idle", bus_if.rdata, 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic r, input logic [1:0] a, input logic [31:0] d);
    bus_if.we    = w;
    bus_if.re    = r;
    bus_if.addr  = ($urandom() & 32'hFFFF_FFF3) | {28'd0, a, 2'b00};
    bus_if.wdata = d;
    @(negedge clk);
    bus_if.we = 1'b0;
    bus_if.re = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_if.we = 1'b0; bus_if.re = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    idle(3);
    rst = 1'b0;
    tick_cnt = 0;

    idle(510);
    chk("default_div_time", time_value, 64'd10);
    chk("default_div_ticks", 64'(tick_cnt), 64'd10);

    drive(1, 0, 2'd3, 32'd0);
    idle(8);
    drive(1, 0, 2'd3, 32'd3);
    idle(12);
    drive(1, 1, 2'd2, 32'd1);
    drive(0, 1, 2'd3, 32'd0);

    drive(1, 0, 2'd3, 32'd1);
    drive(1, 0, 2'd2, 32'd0);
    drive(1, 0, 2'd0, 32'hFFFF_FFFE);
    drive(1, 0, 2'd1, 32'hFFFF_FFFF);
    drive(1, 0, 2'd2, 32'd1);
    idle(1);
    chk("wrap_all_ones", time_value, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(1);
    chk("wrap_zero", time_value, 64'd0);
    chk("wrap_tick", tick, 1'b1);

    drive(1, 0, 2'd2, 32'd0);
    drive(1, 0, 2'd0, 32'hFFFF_FFFF);
    drive(1, 0, 2'd1, 32'd0);
    drive(1, 0, 2'd2, 32'd1);
    drive(0, 1, 2'd0, 32'd0);
    drive(0, 1, 2'd1, 32'd0);
    idle(2);

    drive(1, 0, 2'd3, 32'd10);
    idle(4);
    drive(1, 0, 2'd2, 32'hFFFF_FFFE);
    idle(200);
    chk("frozen_tick", tick, 1'b0);
    drive(1, 0, 2'd2, 32'd1);
    idle(20);

    drive(1, 0, 2'd3, 32'd1);
    drive(1, 0, 2'd1, 32'h0000_1234);
    chk("commit_collision_time", time_value, 64'h0000_1234_FFFF_FFFF);
    chk("commit_collision_tick", tick, 1'b0);
    drive(1, 1, 2'd3, 32'd7);
    idle(2);

    bus_if.re = 1'b1;
    bus_if.addr = 32'h0;
    #2 rst = 1'b1;
    @(negedge clk);
    bus_if.re = 1'b0;
    chk("reset_ack", bus_if.ack, 1'b0);
    chk("reset_time", time_value, 64'd0);
    chk("reset_rdata", bus_if.rdata, 32'd0);
    rst = 1'b0;
    idle(3);

    drive(1, 0, 2'd3, $urandom_range(0, 5));
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 11);
      case (op)
        0:       drive(1, 0, 2'd0, $urandom());
        1:       drive(1, 0, 2'd1, $urandom());
        2:       drive(1, 0, 2'd2, $urandom());
        3:       drive(1, 0, 2'd3, $urandom_range(0, 6));
        4:       drive(1, 1, 2'(op), $urandom_range(0, 6));
        5, 6:    drive(0, 1, 2'd0, 32'd0);
        7:       drive(0, 1, 2'd1, 32'd0);
        8:       drive(0, 1, 2'(3'($urandom_range(2, 3))), 32'd0);
        default: drive(1, 0, 2'd2, 32'd1);
      endcase
      idle($urandom_range(0, 3));
    end
    idle(3);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
